// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - op encodings as presented by the EX stage
//   - controller state encoding
//   - iteration count and the divide-by-zero quotient pattern
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

  // op[1] selects the divide class, op[0] selects the unsigned variant
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shift-add multiplier or restoring divider.
// Ports:
//   is_div   - 1 selects divide step, 0 selects multiply step
//   acc_hi   - multiply: upper partial product; divide: partial remainder
//   acc_lo   - multiply: remaining multiplier bits / low product; divide: quotient being built
//   operand  - multiplicand (multiply) or divisor (divide)
//   nxt_hi/nxt_lo - accumulator after this iteration
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_s   = {acc_hi, acc_lo[WIDTH-1]};
    quo_s   = {acc_lo[WIDTH-2:0], 1'b0};
    rem_ge  = rem_s >= {1'b0, operand};
    // when the trial succeeds the difference is below the divisor, so W bits suffice
    rem_sub = rem_s[WIDTH-1:0] - operand;

    nxt_hi = '0;
    nxt_lo = '0;
    if (is_div) begin
      if (rem_ge) begin
        nxt_hi = rem_sub;
        nxt_lo = {quo_s[WIDTH-1:1], 1'b1};
      end else begin
        nxt_hi = rem_s[WIDTH-1:0];
        nxt_lo = quo_s;
      end
    end else begin
      // 65-bit {carry, acc_hi, acc_lo} shifted right by one
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit feeding the HI/LO register write port.
// Fixed latency: start edge is edge 0, hilo_we is high the cycle after edge 33.
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   start, op      - request and opcode (MULT/MULTU/DIV/DIVU), sampled in IDLE
//   src_a, src_b   - multiplicand/dividend, multiplier/divisor
//   cancel         - pipeline flush, aborts any operation in flight
//   busy           - operation in flight (state != IDLE)
//   hilo_we        - one-cycle HI/LO write strobe
//   hi_o, lo_o     - HI (upper product / remainder), LO (lower product / quotient)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 32 shift-add / restoring-divide iterations
// FIX   | sign correction, results registered into hi_o/lo_o
// DONE  | hilo_we asserted for this cycle
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] orig_a_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic             sign_q, sign_r, div0_q;

  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               last_iter;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div_op(op_q)),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (opnd_q),
    .nxt_hi  (nxt_hi),
    .nxt_lo  (nxt_lo)
  );

  always_comb begin
    abs_a = (is_signed_op(op) && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b = (is_signed_op(op) && src_b[WIDTH-1]) ? -src_b : src_b;
    last_iter = cnt == CNT_W'(ITER_COUNT - 1);
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_neg = -prod;
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    if (is_div_op(op_q)) begin
      if (div0_q) begin
        fix_hi = orig_a_q;
        fix_lo = WIDTH'(DIV0_LO);
      end else if (is_signed_op(op_q)) begin
        fix_hi = sign_r ? -acc_hi : acc_hi;
        fix_lo = sign_q ? -acc_lo : acc_lo;
      end
    end else if (is_signed_op(op_q) && sign_q) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = state != ST_IDLE;
    hilo_we   = state == ST_DONE;
    unique case (state)
      ST_IDLE: if (start && !cancel) state_nxt = ST_RUN;
      ST_RUN:  if (cancel) state_nxt = ST_IDLE;
               else if (last_iter) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = cancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      orig_a_q <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div0_q   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            op_q     <= op;
            orig_a_q <= src_a;
            sign_q   <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
            sign_r   <= src_a[WIDTH-1];
            div0_q   <= is_div_op(op) && (src_b == '0);
            cnt      <= '0;
            acc_hi   <= '0;
            // multiply walks the multiplier through acc_lo; divide shifts the dividend out of it
            if (is_div_op(op)) begin
              opnd_q <= abs_b;
              acc_lo <= abs_a;
            end else begin
              opnd_q <= abs_a;
              acc_lo <= abs_b;
            end
          end
        end
        ST_RUN: begin
          if (!cancel) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            hi_o <= fix_hi;
            lo_o <= fix_lo;
          end
        end
        ST_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        busy, hilo_we;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] prev_hi = 32'h0;
  logic [31:0] prev_lo = 32'h0;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .cancel  (cancel),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    bit seen;
    chk({tag, " busy_pre"}, 32'(busy), 32'd0);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_e0"}, 32'(busy), 32'd1);
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      n = i;
      if (i == 20) chk({tag, " hold_hi"}, hi_o, prev_hi);
      if (hilo_we) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " busy_done"}, 32'(busy), 32'd1);
    chk({tag, " hi"}, hi_o, eh);
    chk({tag, " lo"}, lo_o, el);
    prev_hi = eh;
    prev_lo = el;
    @(posedge clk); #1;
    chk({tag, " we_off"}, 32'(hilo_we), 32'd0);
    chk({tag, " busy_off"}, 32'(busy), 32'd0);
    chk({tag, " hi_kept"}, hi_o, eh);
  endtask

  initial begin
    int n;
    bit seen;
    bit we_seen;
    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst we", 32'(hilo_we), 32'd0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_neg", 2'b01, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_0",    2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
    run_op("div_0",     2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // cancel at edge 10 with start held throughout
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    we_seen = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (hilo_we) we_seen = 1'b1;
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel busy", 32'(busy), 32'd0);
    chk("cancel we", 32'(hilo_we), 32'd0);
    chk("cancel hi", hi_o, prev_hi);
    chk("cancel lo", lo_o, prev_lo);
    chk("cancel no_we_run", 32'(we_seen), 32'd0);
    @(posedge clk); #1;
    chk("restart busy", 32'(busy), 32'd1);
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      n = i;
      if (i == 20) chk("restart hold_lo", lo_o, prev_lo);
      if (hilo_we) seen = 1'b1;
    end
    start = 1'b0;
    chk("restart latency", 32'(n), 32'd33);
    chk("restart hi", hi_o, 32'd2);
    chk("restart lo", lo_o, 32'd14);
    prev_hi = 32'd2;
    prev_lo = 32'd14;
    @(posedge clk); #1;
    chk("restart busy_off", 32'(busy), 32'd0);

    // reset at edge 20 of a MULT
    op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst we", 32'(hilo_we), 32'd0);
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst lo", lo_o, 32'd0);
    rst = 1'b1;
    we_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (hilo_we || busy) we_seen = 1'b1;
    end
    chk("midrst quiet", 32'(we_seen), 32'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;

    run_op("b2b_1", 2'b01, 32'd3,   32'd5,  32'd0, 32'd15);
    run_op("b2b_2", 2'b11, 32'd100, 32'd7,  32'd2, 32'd14);
    run_op("b2b_3", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
